acq_writer: RTL and testbench
=============================

ACQ_WRITER -- requirements
Module: acq_writer

Purpose: ADC capture stage that feeds one port of the shared 16K x 16 sample-memory multiplexer; optional 2^N sample summation before each write.

Interface
REQ-001 SHALL have port clk_i, input, 1, sole clock; all logic on rising edge.
REQ-002 SHALL have port rst_i, input, 1, reset, asynchronous, active-high.
REQ-003 SHALL have port start_i, input, 1, single-cycle arm request.
REQ-004 SHALL have port trig_i, input, 1, acquisition trigger, level sampled each cycle.
REQ-005 SHALL have port abort_i, input, 1, cancel current acquisition.
REQ-006 SHALL have port len_i, input, 14, number of memory words to write; 0 means 16384.
REQ-007 SHALL have port dec_i, input, 2, summation order N; 2^N ADC samples per word.
REQ-008 SHALL have port adc_data_i, input, 12, unsigned ADC sample.
REQ-009 SHALL have port adc_valid_i, input, 1, adc_data_i valid this cycle.
REQ-010 SHALL have port addr_o, output, 14, memory address to mux port.
REQ-011 SHALL have port we_o, output, 1, memory write enable to mux port.
REQ-012 SHALL have port data_o, output, 16, memory write data to mux port.
REQ-013 SHALL have port busy_o, output, 1, high in ARMED or CAPTURE.
REQ-014 SHALL have port done_o, output, 1, high in DONE.
REQ-015 SHALL have port words_o, output, 15, words written in current/last acquisition.

Function
REQ-016 SHALL implement states IDLE, ARMED, CAPTURE, DONE.
REQ-017 SHALL, in IDLE or DONE, on start_i=1 go to ARMED next cycle, latch len_i and dec_i, clear words_o, write index and accumulator.
REQ-018 SHALL, in ARMED, on trig_i=1 go to CAPTURE; trig_i in IDLE/DONE/CAPTURE ignored.
REQ-019 SHALL accept samples only in CAPTURE with adc_valid_i=1; first eligible sample is the cycle after trig_i seen.
REQ-020 SHALL add each accepted sample, zero-extended to 16 bits, into the accumulator; max sum 8 x 4095 = 32760, no overflow.
REQ-021 SHALL, on the accepted sample completing a group of 2^dec, register we_o=1 for exactly one cycle on the next cycle, with addr_o = write index and data_o = group sum including that sample; accumulator restarts at 0 with no sample lost.
REQ-022 SHALL increment write index (wraps 16383->0 only for len 0) and words_o after each write.
REQ-023 SHALL, when words_o reaches latched length (16384 for len 0), enter DONE in the same cycle as that last we_o pulse; further samples ignored.
REQ-024 SHALL hold we_o=0 in all other cycles; addr_o and data_o hold last written values.
REQ-025 SHALL ignore start_i while in ARMED or CAPTURE.
REQ-026 SHALL, on abort_i=1 in any state, go to IDLE next cycle, suppress any pending write, discard partial group, keep words_o.
REQ-027 SHALL give abort_i priority over start_i and trig_i when simultaneous.
REQ-028 SHALL, with start_i and trig_i both high in IDLE, only arm; trigger needed in a later cycle.
REQ-029 SHALL keep done_o high until next start_i or abort_i.

Reset
REQ-030 SHALL on rst_i=1 immediately force IDLE, we_o=0, addr_o=0, data_o=0, busy_o=0, done_o=0, words_o=0, accumulator 0, latched len/dec 0.
REQ-031 SHALL, on reset mid-CAPTURE, issue no further writes after rst_i asserts.
REQ-032 SHALL resume normal operation on first clock edge after rst_i deasserts.

Verification
REQ-033 SHALL cover: len=4, dec=0, start, trig, samples 1,2,3,4 continuous -> writes addr 0..3 data 1,2,3,4, done_o=1, words_o=4.
REQ-034 SHALL cover: len=2, dec=2, samples 10,20,30,40,5,5,5,5 with adc_valid_i gaps -> addr0=100, addr1=20, exactly two we_o pulses.
REQ-035 SHALL cover: dec=3, eight samples 4095 -> data_o=32760.
REQ-036 SHALL cover: len=0, dec=0, 16384 samples -> addresses 0..16383, words_o=16384, done_o=1.
REQ-037 SHALL cover: abort_i on same cycle as group-completing sample -> no we_o, IDLE, words_o unchanged; start+trig in same IDLE cycle -> ARMED only.
REQ-038 SHALL cover: rst_i asserted mid-CAPTURE between clock edges -> outputs zero immediately, no write thereafter.

Source files
------------

// File: rtl/acq_writer.sv
// ADC capture stage for one port of the shared 16K x 16 sample memory.
// Each memory word is the sum of 2^dec consecutive accepted ADC samples.
module acq_writer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        trig_i,
  input  logic        abort_i,
  input  logic [13:0] len_i,
  input  logic [1:0]  dec_i,
  input  logic [11:0] adc_data_i,
  input  logic        adc_valid_i,
  output logic [13:0] addr_o,
  output logic        we_o,
  output logic [15:0] data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [14:0] words_o
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [14:0] len_q;
  logic [1:0]  dec_q;
  logic [15:0] acc;
  logic [2:0]  cnt;
  logic [13:0] idx;
  logic        accept;
  logic        arm;
  logic        group_last;
  logic        last_word;
  logic [15:0] sum;

  assign busy_o = (state == ARMED) || (state == CAPTURE);
  assign done_o = (state == DONE);

  // Abort outranks everything, so it gates both arming and sample acceptance.
  always_comb begin
    accept     = (state == CAPTURE) && adc_valid_i && !abort_i;
    arm        = ((state == IDLE) || (state == DONE)) && start_i && !abort_i;
    sum        = acc + {4'd0, adc_data_i};
    group_last = ({1'b0, cnt} == ((4'd1 << dec_q) - 4'd1));
    last_word  = ((words_o + 15'd1) == len_q);
    state_next = state;
    case (state)
      IDLE, DONE: if (arm) state_next = ARMED;
      ARMED:      if (trig_i) state_next = CAPTURE;
      CAPTURE:    if (accept && group_last && last_word) state_next = DONE;
      default:    state_next = IDLE;
    endcase
    if (abort_i) state_next = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // The write is registered on the edge that accepts the group-completing
  // sample, so the final we_o pulse coincides with the first DONE cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_o    <= 1'b0;
      addr_o  <= '0;
      data_o  <= '0;
      words_o <= '0;
      len_q   <= '0;
      dec_q   <= '0;
      acc     <= '0;
      cnt     <= '0;
      idx     <= '0;
    end else begin
      we_o <= 1'b0;
      if (abort_i) begin
        acc <= '0;
        cnt <= '0;
      end else if (arm) begin
        len_q   <= (len_i == 14'd0) ? 15'd16384 : {1'b0, len_i};
        dec_q   <= dec_i;
        words_o <= '0;
        idx     <= '0;
        acc     <= '0;
        cnt     <= '0;
      end else if (accept) begin
        if (group_last) begin
          we_o    <= 1'b1;
          addr_o  <= idx;
          data_o  <= sum;
          idx     <= idx + 14'd1;
          words_o <= words_o + 15'd1;
          acc     <= '0;
          cnt     <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_acq_writer.sv
// Self-checking bench for acq_writer: directed table, corner sequences and
// randomized acquisitions compared against a group-sum reference model.
module tb_acq_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        trig;
  logic        abort;
  logic [13:0] len;
  logic [1:0]  dec;
  logic [11:0] adc_data;
  logic        adc_valid;
  logic [13:0] addr_o;
  logic        we_o;
  logic [15:0] data_o;
  logic        busy_o;
  logic        done_o;
  logic [14:0] words_o;

  int n_pass  = 0;
  int n_total = 0;

  int wr_addr[$];
  int wr_data[$];

  acq_writer dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .trig_i     (trig),
    .abort_i    (abort),
    .len_i      (len),
    .dec_i      (dec),
    .adc_data_i (adc_data),
    .adc_valid_i(adc_valid),
    .addr_o     (addr_o),
    .we_o       (we_o),
    .data_o     (data_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .words_o    (words_o)
  );

  always #5 clk = ~clk;

  // Every write pulse lasts one cycle, so one negedge sample captures it once.
  always @(negedge clk) begin
    if (we_o) begin
      wr_addr.push_back(int'(addr_o));
      wr_data.push_back(int'(data_o));
    end
  end

  typedef struct {
    int         len;
    int         dec;
    int         nsamp;
    int         samp[8];
    logic [7:0] gap;
    int         nexp;
    int         exp_data[4];
    int         exp_words;
  } vec_t;

  vec_t tbl[4];

  task automatic check_output(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  function automatic int log_addr(input int k);
    return (k < wr_addr.size()) ? wr_addr[k] : -1;
  endfunction

  function automatic int log_data(input int k);
    return (k < wr_data.size()) ? wr_data[k] : -1;
  endfunction

  task automatic apply_stimulus(input int l, input int d);
    clear_log();
    start = 1'b1;
    len   = 14'(l);
    dec   = 2'(d);
    step();
    start = 1'b0;
    trig  = 1'b1;
    step();
    trig  = 1'b0;
  endtask

  task automatic drive_sample(input int s);
    adc_valid = 1'b1;
    adc_data  = 12'(s);
    step();
    adc_valid = 1'b0;
  endtask

  task automatic drive_gap();
    adc_valid = 1'b0;
    adc_data  = 12'($urandom);
    step();
  endtask

  initial begin
    int exp_sums[$];
    int exp_count;
    int errs;
    int grp;
    int acc_m;
    int s;

    rst = 1'b1; start = 0; trig = 0; abort = 0; len = 0; dec = 0;
    adc_data = 0; adc_valid = 0;
    #2;
    check_output("reset_we", int'(we_o), 0);
    check_output("reset_busy", int'(busy_o), 0);
    check_output("reset_done", int'(done_o), 0);
    check_output("reset_words", int'(words_o), 0);
    check_output("reset_addr_data", int'(addr_o) + int'(data_o), 0);
    #10 rst = 1'b0;
    step();

    tbl[0] = '{4, 0, 4, '{1, 2, 3, 4, 0, 0, 0, 0}, 8'h00, 4, '{1, 2, 3, 4}, 4};
    tbl[1] = '{2, 2, 8, '{10, 20, 30, 40, 5, 5, 5, 5}, 8'h56, 2, '{100, 20, 0, 0}, 2};
    tbl[2] = '{1, 3, 8, '{4095, 4095, 4095, 4095, 4095, 4095, 4095, 4095}, 8'h00, 1,
               '{32760, 0, 0, 0}, 1};
    tbl[3] = '{3, 1, 6, '{1, 2, 3, 4, 5, 6, 0, 0}, 8'h24, 3, '{3, 7, 11, 0}, 3};

    for (int v = 0; v < 4; v++) begin
      apply_stimulus(tbl[v].len, tbl[v].dec);
      check_output($sformatf("v%0d_busy_armed", v), int'(busy_o), 1);
      for (int i = 0; i < tbl[v].nsamp; i++) begin
        if (tbl[v].gap[i]) drive_gap();
        drive_sample(tbl[v].samp[i]);
      end
      drive_sample(12'hABC);
      step();
      check_output($sformatf("v%0d_nwrites", v), wr_data.size(), tbl[v].nexp);
      for (int k = 0; k < tbl[v].nexp; k++) begin
        check_output($sformatf("v%0d_addr%0d", v, k), log_addr(k), k);
        check_output($sformatf("v%0d_data%0d", v, k), log_data(k), tbl[v].exp_data[k]);
      end
      check_output($sformatf("v%0d_words", v), int'(words_o), tbl[v].exp_words);
      check_output($sformatf("v%0d_done", v), int'(done_o), 1);
      check_output($sformatf("v%0d_busy", v), int'(busy_o), 0);
    end

    // Full 16384-word acquisition with len 0.
    apply_stimulus(0, 0);
    for (int i = 0; i < 16384; i++) drive_sample((i * 7) & 12'hFFF);
    drive_sample(1);
    step();
    check_output("full_nwrites", wr_data.size(), 16384);
    errs = 0;
    for (int i = 0; i < 16384; i++)
      if (log_addr(i) != i || log_data(i) != ((i * 7) & 12'hFFF)) errs++;
    check_output("full_content_errs", errs, 0);
    check_output("full_words", int'(words_o), 16384);
    check_output("full_done", int'(done_o), 1);

    // Abort coinciding with a group-completing sample.
    apply_stimulus(4, 1);
    drive_sample(1);
    drive_sample(2);
    drive_sample(5);
    abort = 1'b1;
    drive_sample(6);
    abort = 1'b0;
    step();
    check_output("abort_nwrites", wr_data.size(), 1);
    check_output("abort_data0", log_data(0), 3);
    check_output("abort_words_kept", int'(words_o), 1);
    check_output("abort_idle", int'(busy_o) + int'(done_o), 0);
    apply_stimulus(1, 1);
    drive_sample(10);
    drive_sample(20);
    step();
    check_output("abort_partial_discarded", log_data(0), 30);

    // Start and trigger together only arm.
    clear_log();
    start = 1'b1; trig = 1'b1; len = 14'd1; dec = 2'd0;
    step();
    start = 1'b0; trig = 1'b0;
    for (int i = 0; i < 3; i++) drive_sample(55);
    check_output("starttrig_nwrites", wr_data.size(), 0);
    check_output("starttrig_armed", int'(busy_o), 1);
    trig = 1'b1;
    step();
    trig = 1'b0;
    drive_sample(66);
    step();
    check_output("starttrig_data", log_data(0), 66);
    check_output("starttrig_done", int'(done_o), 1);

    // Reset asserted between edges mid-capture.
    apply_stimulus(4, 0);
    drive_sample(9);
    adc_valid = 1'b1;
    adc_data  = 12'd8;
    clear_log();
    #2 rst = 1'b1;
    #1;
    check_output("rst_mid_we", int'(we_o), 0);
    check_output("rst_mid_words", int'(words_o), 0);
    check_output("rst_mid_outs", int'(addr_o) + int'(data_o) + int'(busy_o), 0);
    step();
    step();
    adc_valid = 1'b0;
    #3 rst = 1'b0;
    step();
    check_output("rst_mid_nowrites", wr_data.size(), 0);
    apply_stimulus(1, 0);
    drive_sample(77);
    step();
    check_output("rst_resume_data", log_data(0), 77);
    check_output("rst_resume_addr", log_addr(0), 0);

    // Randomized acquisitions against the group-sum model.
    for (int r = 0; r < 8; r++) begin
      int rl;
      int rd;
      rl = $urandom_range(1, 12);
      rd = $urandom_range(0, 3);
      exp_sums.delete();
      apply_stimulus(rl, rd);
      grp   = 1 << rd;
      acc_m = 0;
      for (int i = 0; i < rl * grp; i++) begin
        if ($urandom_range(0, 9) < 3) drive_gap();
        s = $urandom_range(0, 4095);
        drive_sample(s);
        acc_m += s;
        if ((i % grp) == grp - 1) begin
          exp_sums.push_back(acc_m);
          acc_m = 0;
        end
      end
      for (int i = 0; i < 3; i++) drive_sample($urandom_range(0, 4095));
      step();
      exp_count = exp_sums.size();
      check_output($sformatf("rnd%0d_nwrites", r), wr_data.size(), exp_count);
      errs = 0;
      for (int k = 0; k < exp_count; k++)
        if (log_addr(k) != k || log_data(k) != exp_sums[k]) errs++;
      check_output($sformatf("rnd%0d_content_errs", r), errs, 0);
      check_output($sformatf("rnd%0d_words", r), int'(words_o), rl);
      check_output($sformatf("rnd%0d_done", r), int'(done_o), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
